// File: rtl/hack_boot_loader.sv
// rtl/hack_boot_loader.sv - Hack instruction-ROM boot loader and CPU reset sequencer.
// Optional trailing checksum word is compiled in with BOOT_CHECKSUM_EN.
module hack_boot_loader #(
  parameter int ADDR_W   = 15,
  parameter int HOLD_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_data,
  output logic              cpu_reset,
  output logic              boot_done,
  output logic              boot_error
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
`ifdef BOOT_CHECKSUM_EN
    S_CHK,
`endif
    S_HOLD,
    S_RUN,
    S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     len_q, len_d;
  logic [7:0]        hold_q, hold_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]       rom_data_q, rom_data_d;
`ifdef BOOT_CHECKSUM_EN
  logic [15:0]       sum_q, sum_d;
`endif

  logic          xfer;
  logic          len_ok;
  logic [CW-1:0] cnt_inc;

  assign xfer    = in_valid & in_ready;
  // Length must be non-zero and fit in the ROM; 2^ADDR_W itself is legal.
  assign len_ok  = (in_data != 16'd0) && (32'(in_data) <= (32'd1 << ADDR_W));
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    hold_d     = hold_q;
    rom_we_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) state_d = S_LEN;
      end
      S_LEN: begin
        if (xfer) begin
          cnt_d  = '0;
          len_d  = CW'(in_data);
`ifdef BOOT_CHECKSUM_EN
          sum_d  = 16'd0;
`endif
          state_d = len_ok ? S_LOAD : S_ERROR;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          rom_we_d   = 1'b1;
          rom_addr_d = cnt_q[ADDR_W-1:0];
          rom_data_d = in_data;
          cnt_d      = cnt_inc;
`ifdef BOOT_CHECKSUM_EN
          sum_d      = sum_q + in_data;
`endif
          if (cnt_inc == len_q) begin
            hold_d = 8'd0;
`ifdef BOOT_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_HOLD;
`endif
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          hold_d  = 8'd0;
          state_d = (in_data == sum_q) ? S_HOLD : S_ERROR;
        end
      end
`endif
      S_HOLD: begin
        hold_d = hold_q + 8'd1;
        if (hold_q == 8'(HOLD_CYC - 1)) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      hold_q     <= 8'd0;
      rom_we_q   <= 1'b0;
      rom_addr_q <= '0;
      rom_data_q <= 16'd0;
`ifdef BOOT_CHECKSUM_EN
      sum_q      <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      hold_q     <= hold_d;
      rom_we_q   <= rom_we_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign rom_we     = rom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
`ifdef BOOT_CHECKSUM_EN
  assign in_ready   = (state_q == S_LEN) || (state_q == S_LOAD) || (state_q == S_CHK);
`else
  assign in_ready   = (state_q == S_LEN) || (state_q == S_LOAD);
`endif
  assign cpu_reset  = (state_q != S_RUN);
  assign boot_done  = (state_q == S_RUN);
  assign boot_error = (state_q == S_ERROR);

endmodule

// File: tb/tb_hack_boot_loader.sv
// tb/tb_hack_boot_loader.sv - directed self-checking bench for hack_boot_loader.
module tb_hack_boot_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic        in_ready;
  logic        rom_we;
  logic [14:0] rom_addr;
  logic [15:0] rom_data;
  logic        cpu_reset;
  logic        boot_done;
  logic        boot_error;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [14:0] a;
    logic [15:0] d;
    time         t;
  } wr_t;
  wr_t         wlog[$];
  logic [15:0] rom_m [0:32767];

  hack_boot_loader #(.ADDR_W(15), .HOLD_CYC(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
    .cpu_reset(cpu_reset), .boot_done(boot_done), .boot_error(boot_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_we) begin
      wr_t w;
      w.a = rom_addr;
      w.d = rom_data;
      w.t = $time;
      wlog.push_back(w);
      rom_m[rom_addr] = rom_data;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL send_word timeout: in_ready=%0b required 1 for word %h", in_ready, w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_sum(input logic [15:0] s);
`ifdef BOOT_CHECKSUM_EN
    send_word(s);
`endif
  endtask

  task automatic wait_hold_run(input string tag);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (boot_done !== 1'b1 || cpu_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL %s run: boot_done=%b cpu_reset=%b required 1/0", tag, boot_done, cpu_reset);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if ({cpu_reset, in_ready, rom_we, boot_done, boot_error} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset flags: got %b required 10000",
               {cpu_reset, in_ready, rom_we, boot_done, boot_error});
    end
    n_checks++;
    if (rom_addr !== 15'd0 || rom_data !== 16'd0) begin
      n_fail++;
      $display("FAIL reset rom bus: addr=%h data=%h required 0/0", rom_addr, rom_data);
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp_d [3];
    exp_d[0] = 16'h0002; exp_d[1] = 16'hEC10; exp_d[2] = 16'h0003;
    wlog.delete();
    pulse_start();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic len ready: in_ready=%b required 1", in_ready);
    end
    send_word(16'd3);
    for (int i = 0; i < 3; i++) send_word(exp_d[i]);
    send_sum(16'hEC15);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (cpu_reset !== 1'b1 || boot_done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic early release: cpu_reset=%b boot_done=%b required 1/0", cpu_reset, boot_done);
    end
    @(posedge clk); #1;
    n_checks++;
    if (cpu_reset !== 1'b0 || boot_done !== 1'b1) begin
      n_fail++;
      $display("FAIL basic release: cpu_reset=%b boot_done=%b required 0/1", cpu_reset, boot_done);
    end
    n_checks++;
    if (wlog.size() !== 3) begin
      n_fail++;
      $display("FAIL basic write count: got %0d required 3", wlog.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (wlog[i].a !== 15'(i) || wlog[i].d !== exp_d[i]) begin
          n_fail++;
          $display("FAIL basic write %0d: got (%h,%h) required (%h,%h)", i, wlog[i].a, wlog[i].d, i, exp_d[i]);
        end
      end
      n_checks++;
      if (wlog[1].t - wlog[0].t !== 10 || wlog[2].t - wlog[1].t !== 10) begin
        n_fail++;
        $display("FAIL basic spacing: got %0t,%0t required 10,10", wlog[1].t - wlog[0].t, wlog[2].t - wlog[1].t);
      end
    end
  endtask

  task automatic test_len_zero();
    wlog.delete();
    pulse_start();
    send_word(16'd0);
    n_checks++;
    if (boot_error !== 1'b1 || cpu_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL len0 error: boot_error=%b cpu_reset=%b required 1/1", boot_error, cpu_reset);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (wlog.size() !== 0) begin
      n_fail++;
      $display("FAIL len0 writes: got %0d required 0", wlog.size());
    end
    pulse_start();
    n_checks++;
    if (boot_error !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL len0 restart: boot_error=%b in_ready=%b required 0/1", boot_error, in_ready);
    end
    send_word(16'd1);
    send_word(16'h1234);
    send_sum(16'h1234);
    wait_hold_run("len0 recover");
  endtask

  task automatic test_len_over();
    pulse_start();
    send_word(16'h8001);
    n_checks++;
    if (boot_error !== 1'b1 || cpu_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL len_over: boot_error=%b cpu_reset=%b required 1/1", boot_error, cpu_reset);
    end
  endtask

  task automatic test_full();
    wlog.delete();
    pulse_start();
    send_word(16'h8000);
    for (int i = 0; i < 32768; i++) send_word(16'(i));
    send_sum(16'hC000);
    wait_hold_run("full");
    n_checks++;
    if (wlog.size() !== 32768) begin
      n_fail++;
      $display("FAIL full count: got %0d required 32768", wlog.size());
    end else begin
      n_checks++;
      if (wlog[32767].a !== 15'h7FFF || wlog[32767].d !== 16'h7FFF || wlog[0].a !== 15'h0) begin
        n_fail++;
        $display("FAIL full last: got (%h,%h) first addr %h required (7fff,7fff) first 0",
                 wlog[32767].a, wlog[32767].d, wlog[0].a);
      end
    end
  endtask

  task automatic test_checksum();
`ifdef BOOT_CHECKSUM_EN
    pulse_start();
    send_word(16'd2); send_word(16'd1); send_word(16'd2); send_word(16'd4);
    n_checks++;
    if (boot_error !== 1'b1) begin
      n_fail++;
      $display("FAIL chk mismatch: boot_error=%b required 1", boot_error);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rom_m[0] !== 16'd1 || rom_m[1] !== 16'd2) begin
      n_fail++;
      $display("FAIL chk rom kept: got %h,%h required 0001,0002", rom_m[0], rom_m[1]);
    end
    pulse_start();
    send_word(16'd2); send_word(16'd1); send_word(16'd2); send_word(16'd3);
    wait_hold_run("chk good");
`endif
  endtask

  task automatic test_valid_toggle();
    wlog.delete();
    pulse_start();
    send_word(16'd4);
    for (int i = 0; i < 4; i++) begin
      send_word(16'hA000 + 16'(i));
      @(posedge clk); #1;
    end
    send_sum(16'h8006);
    wait_hold_run("toggle");
    n_checks++;
    if (wlog.size() !== 4) begin
      n_fail++;
      $display("FAIL toggle count: got %0d required 4", wlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (wlog[i].a !== 15'(i) || wlog[i].d !== 16'hA000 + 16'(i)) begin
          n_fail++;
          $display("FAIL toggle write %0d: got (%h,%h) required (%h,%h)", i, wlog[i].a, wlog[i].d, i, 16'hA000 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_run_restart();
    pulse_start();
    n_checks++;
    if (cpu_reset !== 1'b1 || in_ready !== 1'b1 || boot_done !== 1'b0) begin
      n_fail++;
      $display("FAIL run restart: cpu_reset=%b in_ready=%b boot_done=%b required 1/1/0", cpu_reset, in_ready, boot_done);
    end
  endtask

  task automatic test_reset_mid();
    wlog.delete();
    send_word(16'd5);
    send_word(16'h1111);
    send_word(16'h2222);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (cpu_reset !== 1'b1 || rom_we !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid reset: cpu_reset=%b rom_we=%b in_ready=%b required 1/0/0", cpu_reset, rom_we, in_ready);
    end
    in_valid = 1'b1;
    in_data  = 16'h3333;
    repeat (10) @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (wlog.size() !== 2 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid reset idle: writes=%0d in_ready=%b required 2/0", wlog.size(), in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_len_over();
    test_full();
    test_checksum();
    test_valid_toggle();
    test_run_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
